multdiv_issue_ctrl: RTL and testbench

//  Sits between the pipeline execute stage and the mult/div units. Latches one op,

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_timeout_cnt.sv | 35 +++
 rtl/multdiv_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the mult/div issue controller.
// Contents: FSM state encoding, op-select constants, default watchdog limit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/multdiv_timeout_cnt.sv
// Watchdog counter for the WAIT state of the mult/div issue controller.
// Only instantiated when MULTDIV_TIMEOUT_EN is defined.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   clear          : synchronous clear (controller not in WAIT)
//   enable         : count one per cycle (controller in WAIT)
//   expired        : count has reached LIMIT; holds until cleared
module multdiv_timeout_cnt #(
  parameter int unsigned LIMIT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT));

  // Saturates at LIMIT so expired stays asserted until the controller leaves WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between the execute stage and the mult/div units.
// Latches one op, holds its operands on unit_opA/unit_opB for the whole op,
// pulses ctrl_MULT or ctrl_DIV for one cycle, waits for the unit's ready and
// returns result/exception/tag to the consumer. busy stalls upstream.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready may be asserted independently of valid. in_ready is high only in
// IDLE; out_valid is high only in DONE and its payload is stable until taken.
//
// Ports:
//   clock, reset_n               : clock, asynchronous active-low reset
//   in_valid/in_ready            : request handshake
//   in_is_div, in_opA/B, in_tag  : request payload
//   unit_opA/B                   : held operands to both units
//   ctrl_MULT/ctrl_DIV           : one-cycle unit start pulses
//   mult_*/div_*                 : unit result, exception, result-ready
//   out_valid/out_ready          : response handshake
//   out_result, out_exc, out_tag : response payload
//   busy                         : high whenever not IDLE
//   dbg_state                    : current FSM state (multdiv_pkg::state_t encoding)
//
// Configuration macro: MULTDIV_TIMEOUT_EN enables a WAIT watchdog that ends the
// op with result=0, exc=1 after TIMEOUT_CYCLES cycles without a ready.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int          TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_div,
  input  logic [31:0]      in_opA,
  input  logic [31:0]      in_opB,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      unit_opA,
  output logic [31:0]      unit_opB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  input  logic [31:0]      mult_result,
  input  logic             mult_exc,
  input  logic             mult_rdy,
  input  logic [31:0]      div_result,
  input  logic             div_exc,
  input  logic             div_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_exc,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_t             state;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               op_is_div;
  logic [TAG_W-1:0]   op_tag;
  logic [31:0]        res_q;
  logic               exc_q;
  logic               ctrl_mult_q;
  logic               ctrl_div_q;
  logic               wait_first;
  logic               timeout_hit;

  logic               sel_rdy;
  logic [31:0]        sel_result;
  logic               sel_exc;

  assign sel_rdy    = (op_is_div == OP_DIV) ? div_rdy    : mult_rdy;
  assign sel_result = (op_is_div == OP_DIV) ? div_result : mult_result;
  assign sel_exc    = (op_is_div == OP_DIV) ? div_exc    : mult_exc;

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state != ST_WAIT),
    .enable  (state == ST_WAIT),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  // The limit has no effect without the watchdog; referencing it here keeps
  // an override of the parameter meaningful to elaboration in both builds.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_is_div   <= OP_MULT;
      op_tag      <= '0;
      res_q       <= '0;
      exc_q       <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wait_first  <= 1'b0;
    end else begin
      // Start pulses are only ever set on the IDLE->START edge, so they are
      // high exactly for the single START cycle.
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a      <= in_opA;
            op_b      <= in_opB;
            op_is_div <= in_is_div;
            op_tag    <= in_tag;
            if ((in_is_div == OP_DIV) && (in_opB == 32'd0)) begin
              // Divide by zero never reaches the divider.
              res_q <= '0;
              exc_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              ctrl_mult_q <= (in_is_div == OP_MULT);
              ctrl_div_q  <= (in_is_div == OP_DIV);
              state       <= ST_START;
            end
          end
        end
        ST_START: begin
          wait_first <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_first <= 1'b0;
          // The unit's ready is left over from its previous op until its
          // internal counter clears, so it is not trusted in the first cycle.
          if (!wait_first && sel_rdy) begin
            res_q <= sel_result;
            exc_q <= sel_exc;
            state <= ST_DONE;
          end else if (timeout_hit) begin
            res_q <= '0;
            exc_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign unit_opA   = op_a;
  assign unit_opB   = op_b;
  assign ctrl_MULT  = ctrl_mult_q;
  assign ctrl_DIV   = ctrl_div_q;
  assign out_result = res_q;
  assign out_exc    = exc_q;
  assign out_tag    = op_tag;
  assign dbg_state  = state;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with simple mult/div unit models and
// a scoreboard queue of expected {exc, tag, result} responses.
module tb_multdiv_issue_ctrl;

  localparam int TAG_W    = 5;
  localparam int MULT_LAT = 16;
  localparam int DIV_LAT  = 20;
  localparam int RES_W    = 1 + TAG_W + 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic             in_is_div;
  logic [31:0]      in_opA;
  logic [31:0]      in_opB;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      unit_opA;
  logic [31:0]      unit_opB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [31:0]      mult_result;
  logic             mult_exc;
  logic             mult_rdy;
  logic [31:0]      div_result;
  logic             div_exc;
  logic             div_rdy;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_exc;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [1:0]       dbg_state;

  // clock / reset
  always #5 clock = ~clock;

  multdiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(40)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_div(in_is_div),
    .in_opA(in_opA), .in_opB(in_opB), .in_tag(in_tag),
    .unit_opA(unit_opA), .unit_opB(unit_opB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .mult_result(mult_result), .mult_exc(mult_exc), .mult_rdy(mult_rdy),
    .div_result(div_result), .div_exc(div_exc), .div_rdy(div_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exc(out_exc), .out_tag(out_tag),
    .busy(busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mult_pulses = 0;
  int div_pulses = 0;
  logic [RES_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // unit models: inputs change on the falling edge only
  int           m_cnt = 0;
  int           d_cnt = 0;
  logic         mult_rdy_m = 1'b0;
  logic [31:0]  mult_res_m = '0;
  logic         mult_exc_m = 1'b0;
  logic         stale_rdy = 1'b0;
  logic         mute_units = 1'b0;
  logic signed [63:0] prod;

  assign mult_rdy    = mult_rdy_m | stale_rdy;
  assign mult_result = stale_rdy ? 32'hDEAD_BEEF : mult_res_m;
  assign mult_exc    = stale_rdy ? 1'b1 : mult_exc_m;

  always @(negedge clock) begin
    if (!reset_n) begin
      m_cnt = 0; d_cnt = 0; mult_rdy_m = 1'b0; div_rdy = 1'b0;
    end else begin
      mult_rdy_m = 1'b0;
      div_rdy    = 1'b0;
      if (ctrl_MULT) m_cnt = MULT_LAT;
      else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0 && !mute_units) begin
          prod       = $signed(unit_opA) * $signed(unit_opB);
          mult_res_m = prod[31:0];
          mult_exc_m = (prod != {{32{prod[31]}}, prod[31:0]});
          mult_rdy_m = 1'b1;
        end
      end
      if (ctrl_DIV) d_cnt = DIV_LAT;
      else if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0 && !mute_units) begin
          div_result = $signed(unit_opA) / $signed(unit_opB);
          div_exc    = 1'b0;
          div_rdy    = 1'b1;
        end
      end
    end
  end

  // scoreboard / pulse monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (ctrl_MULT) mult_pulses++;
      if (ctrl_DIV) div_pulses++;
      if (ctrl_MULT || ctrl_DIV) begin
        check("ctrl_exclusive", 64'(ctrl_MULT & ctrl_DIV), 64'd0);
        check("ctrl_in_start", 64'(dbg_state), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
        else check("response", 64'({out_exc, out_tag, out_result}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic send_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic [31:0] er, input logic ee);
    int guard = 0;
    in_valid = 1'b1; in_is_div = d; in_opA = a; in_opB = b; in_tag = t;
    exp_q.push_back({ee, t, er});
    while (!in_ready && guard < 300) begin
      @(posedge clock); #1; guard++;
    end
    check("accept_bound", 64'(guard < 300), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clock); #1; cyc++;
    end
    check("valid_bound", 64'(cyc < 300), 64'd1);
  endtask

  int lat;
  int mp0;
  int dp0;

  initial begin
    in_valid = 1'b0; in_is_div = 1'b0; in_opA = '0; in_opB = '0; in_tag = '0;
    out_ready = 1'b1; div_result = '0; div_exc = 1'b0; div_rdy = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl", 64'({ctrl_MULT, ctrl_DIV}), 64'd0);
    check("rst_operands", 64'({unit_opA, unit_opB}), 64'd0);
    check("rst_result", 64'({out_exc, out_tag, out_result}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // mult 7 x -3
    mp0 = mult_pulses; dp0 = div_pulses;
    send_op(1'b0, 32'd7, -32'sd3, 5'd5, 32'hFFFF_FFEB, 1'b0);
    check("mult_start_pulse", 64'({ctrl_MULT, ctrl_DIV}), 64'b10);
    check("mult_busy", 64'({busy, in_ready}), 64'b10);
    wait_valid(lat);
    check("mult_latency", 64'(lat), 64'd17);
    @(posedge clock); #1;
    check("mult_pulse_count", 64'(mult_pulses - mp0), 64'd1);
    check("mult_no_div", 64'(div_pulses - dp0), 64'd0);
    check("mult_back_idle", 64'(dbg_state), 64'd0);

    // overflowing mult
    send_op(1'b0, 32'h4000_0000, 32'd4, 5'd3, 32'd0, 1'b1);
    wait_valid(lat);
    @(posedge clock); #1;

    // div 100 / 7
    mp0 = mult_pulses; dp0 = div_pulses;
    send_op(1'b1, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0);
    check("div_start_pulse", 64'({ctrl_MULT, ctrl_DIV}), 64'b01);
    wait_valid(lat);
    check("div_latency", 64'(lat), 64'(DIV_LAT + 1));
    @(posedge clock); #1;
    check("div_pulse_count", 64'(div_pulses - dp0), 64'd1);
    check("div_no_mult", 64'(mult_pulses - mp0), 64'd0);

    // div by zero
    dp0 = div_pulses;
    send_op(1'b1, 32'd5, 32'd0, 5'd2, 32'd0, 1'b1);
    check("div0_valid_next", 64'(out_valid), 64'd1);
    check("div0_state", 64'(dbg_state), 64'd3);
    @(posedge clock); #1;
    check("div0_no_pulse", 64'(div_pulses - dp0), 64'd0);

    // back-pressure in DONE, second op queued behind it
    out_ready = 1'b0;
    send_op(1'b0, 32'd6, 32'd7, 5'd11, 32'd42, 1'b0);
    wait_valid(lat);
    in_valid = 1'b1; in_is_div = 1'b1; in_opA = 32'd81; in_opB = 32'd9; in_tag = 5'd12;
    exp_q.push_back({1'b0, 5'd12, 32'd9});
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("hold_payload", 64'({out_valid, out_exc, out_tag, out_result}), 64'({1'b1, 1'b0, 5'd11, 32'd42}));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("handshake_idle", 64'({dbg_state, in_ready}), 64'({2'd0, 1'b1}));
    @(posedge clock); #1;
    check("second_accept", 64'({dbg_state, ctrl_DIV}), 64'({2'd1, 1'b1}));
    in_valid = 1'b0;
    wait_valid(lat);
    @(posedge clock); #1;

    // stale mult ready across START and the first WAIT cycle
    send_op(1'b0, 32'd12, 32'd12, 5'd7, 32'd144, 1'b0);
    stale_rdy = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    stale_rdy = 1'b0;
    check("stale_ignored", 64'({out_valid, dbg_state}), 64'({1'b0, 2'd2}));
    wait_valid(lat);
    check("stale_latency", 64'(lat), 64'd15);
    @(posedge clock); #1;

    // asynchronous reset during WAIT
    send_op(1'b0, 32'd3, 32'd5, 5'd1, 32'd15, 1'b0);
    repeat (4) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("areset_state", 64'({dbg_state, in_ready, busy, out_valid}), 64'({2'd0, 1'b1, 1'b0, 1'b0}));
    check("areset_operands", 64'(unit_opA), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    check("areset_no_output", 64'(out_valid), 64'd0);
    send_op(1'b0, 32'd2, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 1'b0);
    wait_valid(lat);
    @(posedge clock); #1;

`ifdef MULTDIV_TIMEOUT_EN
    mute_units = 1'b1;
    send_op(1'b0, 32'd9, 32'd9, 5'd4, 32'd0, 1'b1);
    wait_valid(lat);
    @(posedge clock); #1;
    mute_units = 1'b0;
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
